// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the CPU instruction/data ports, the arbiter and the little-endian RAM.
// The arbiter uses the slave view; the CPU and RAM environment use the master view.
interface mem_bus_arbiter_if;
  logic        instr_read;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        instr_waitrequest;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_address;
  logic [3:0]  data_byteenable;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        data_waitrequest;
  logic [31:0] ram_address;
  logic        ram_read;
  logic        ram_write;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata;
  logic        ram_waitrequest;
  logic        bus_error;

  modport slave (
    input  instr_read, instr_address,
    output instr_readdata, instr_waitrequest,
    input  data_read, data_write, data_address, data_byteenable, data_writedata,
    output data_readdata, data_waitrequest,
    output ram_address, ram_read, ram_write, ram_byteenable, ram_writedata,
    input  ram_readdata, ram_waitrequest,
    output bus_error
  );

  modport master (
    output instr_read, instr_address,
    input  instr_readdata, instr_waitrequest,
    output data_read, data_write, data_address, data_byteenable, data_writedata,
    input  data_readdata, data_waitrequest,
    input  ram_address, ram_read, ram_write, ram_byteenable, ram_writedata,
    output ram_readdata, ram_waitrequest,
    input  bus_error
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one little-endian RAM port between big-endian CPU fetch and data ports,
// with byte-lane swapping at the boundary and a watchdog that aborts stalled accesses.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_bus_arbiter_if.slave    bus
);

  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BUS_I = 3'd1,
    BUS_D = 3'd2,
    ACK_I = 3'd3,
    ACK_D = 3'd4
  } state_t;

  function automatic logic [31:0] swap_bytes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [3:0] rev_be(input logic [3:0] b);
    return {b[0], b[1], b[2], b[3]};
  endfunction

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     irdata_q, irdata_d;
  logic [31:0]     drdata_q, drdata_d;
  logic [3:0]      be_q, be_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic            err_q, err_d;
  logic            last_q, last_d;   // 1'b1 = data port granted last
  logic [WD_W-1:0] wd_q, wd_d;

  logic req_i_s, req_d_s, grant_i_s, grant_d_s, done_s, abort_s;

  assign req_i_s   = bus.instr_read;
  assign req_d_s   = bus.data_read | bus.data_write;
  assign grant_i_s = req_i_s & (~req_d_s | last_q);
  assign grant_d_s = req_d_s & (~req_i_s | ~last_q);
  assign done_s    = ~bus.ram_waitrequest;
  assign abort_s   = bus.ram_waitrequest & (wd_q == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      irdata_q <= 32'h0;
      drdata_q <= 32'h0;
      be_q     <= 4'h0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      last_q   <= 1'b0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      be_q     <= be_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      last_q   <= last_d;
      wd_q     <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_i_s) begin
          state_d = BUS_I;
        end else if (grant_d_s) begin
          state_d = BUS_D;
        end else begin
          state_d = IDLE;
        end
      end
      BUS_I: begin
        if (done_s || abort_s) state_d = ACK_I;
        else                   state_d = BUS_I;
      end
      BUS_D: begin
        if (done_s || abort_s) state_d = ACK_D;
        else                   state_d = BUS_D;
      end
      ACK_I:   state_d = IDLE;
      ACK_D:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    be_d     = be_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    err_d    = err_q;
    last_d   = last_q;
    wd_d     = wd_q;
    case (state_q)
      IDLE: begin
        if (grant_i_s) begin
          addr_d = bus.instr_address;
          rd_d   = 1'b1;
          wr_d   = 1'b0;
          be_d   = 4'hF;
          last_d = 1'b0;
          wd_d   = '0;
        end else if (grant_d_s) begin
          // simultaneous read and write is treated as a write
          addr_d  = bus.data_address;
          rd_d    = bus.data_read & ~bus.data_write;
          wr_d    = bus.data_write;
          be_d    = rev_be(bus.data_byteenable);
          wdata_d = swap_bytes(bus.data_writedata);
          last_d  = 1'b1;
          wd_d    = '0;
        end else begin
          wd_d = wd_q;
        end
      end
      BUS_I, BUS_D: begin
        if (done_s) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (rd_q && (state_q == BUS_I)) begin
            irdata_d = swap_bytes(bus.ram_readdata);
          end else if (rd_q) begin
            drdata_d = swap_bytes(bus.ram_readdata);
          end else begin
            drdata_d = drdata_q;
          end
        end else if (abort_s) begin
          rd_d  = 1'b0;
          wr_d  = 1'b0;
          err_d = 1'b1;
          if (state_q == BUS_I) irdata_d = 32'h0;
          else                  drdata_d = 32'h0;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: begin
        wd_d = wd_q;
      end
    endcase
  end

  always_comb begin
    bus.instr_waitrequest = bus.instr_read & (state_q != ACK_I);
    bus.data_waitrequest  = (bus.data_read | bus.data_write) & (state_q != ACK_D);
    bus.instr_readdata    = irdata_q;
    bus.data_readdata     = drdata_q;
    bus.ram_address       = addr_q;
    bus.ram_read          = rd_q;
    bus.ram_write         = wr_q;
    bus.ram_byteenable    = be_q;
    bus.ram_writedata     = wdata_q;
    bus.bus_error         = err_q;
  end

endmodule
